l1_l2_arbiter: RTL and testbench



---
 rtl/l1_l2_arbiter.sv | 152 +++++++++++++++
 tb/tb_l1_l2_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: shares the single L2 port between the L1 I-cache and D-cache.
// Each grant latches the winner's address, write data and op, so the arb_*
// request stays stable for the whole L2 transaction. The L2 response is passed
// straight through to whichever client holds the grant.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// contention; by default the D-cache always wins contention.
module l1_l2_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         icache_read,
  input  logic [15:0]  icache_address,
  output logic         icache_resp,
  output logic [127:0] icache_rdata,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [15:0]  dcache_address,
  input  logic [127:0] dcache_wdata,
  output logic         dcache_resp,
  output logic [127:0] dcache_rdata,
  output logic         arb_read,
  output logic         arb_write,
  output logic [15:0]  arb_address,
  output logic [127:0] arb_wdata,
  input  logic         L2_resp,
  input  logic [127:0] arb_rdata
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   req_addr;
  logic [LINE_W-1:0]   req_wdata;
  logic                req_read;
  logic                req_write;
  logic                i_pending;
  logic                d_pending;
  logic                pick_i;
  logic                grant_i;
  logic                grant_d;

  assign i_pending = icache_read;
  assign d_pending = dcache_read | dcache_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = the D-cache held the most recent grant; reset value favours I first
  logic last_grant_d;

  // Contention goes to the client that did not win last time
  assign pick_i = i_pending & (~d_pending | last_grant_d);

  // Record the winner of every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_d <= 1'b1;
    end else if (grant_i) begin
      last_grant_d <= 1'b0;
    end else if (grant_d) begin
      last_grant_d <= 1'b1;
    end
  end
`else
  // Fixed priority: the D-cache wins any contention
  assign pick_i = i_pending & ~d_pending;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, grant and pass-through response strobes
  always_comb begin
    state_d     = state_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    icache_resp = 1'b0;
    dcache_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_i) begin
          grant_i = 1'b1;
          state_d = SERVE_I;
        end else if (d_pending) begin
          grant_d = 1'b1;
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        if (L2_resp) begin
          icache_resp = 1'b1;
          state_d     = IDLE;
        end
      end
      SERVE_D: begin
        if (L2_resp) begin
          dcache_resp = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the granted request; strobes drop as the L2 transaction completes
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_read  <= 1'b0;
      req_write <= 1'b0;
    end else if (grant_i) begin
      req_addr  <= icache_address;
      req_wdata <= '0;
      req_read  <= 1'b1;
      req_write <= 1'b0;
    end else if (grant_d) begin
      // A simultaneous read and write is illegal; the write takes precedence
      req_addr  <= dcache_address;
      req_wdata <= dcache_wdata;
      req_read  <= ~dcache_write;
      req_write <= dcache_write;
    end else if (L2_resp && (state_q != IDLE)) begin
      req_read  <= 1'b0;
      req_write <= 1'b0;
    end
  end

  // Request side is driven directly from the latched registers
  assign arb_read    = req_read;
  assign arb_write   = req_write;
  assign arb_address = req_addr;
  assign arb_wdata   = req_wdata;

  // Read data fans out to both clients; only the resp strobe qualifies it
  assign icache_rdata = arb_rdata;
  assign dcache_rdata = arb_rdata;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed testbench for l1_l2_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit after that.
module tb_l1_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_read;
  logic [15:0]  icache_address;
  logic         icache_resp;
  logic [127:0] icache_rdata;
  logic         dcache_read;
  logic         dcache_write;
  logic [15:0]  dcache_address;
  logic [127:0] dcache_wdata;
  logic         dcache_resp;
  logic [127:0] dcache_rdata;
  logic         arb_read;
  logic         arb_write;
  logic [15:0]  arb_address;
  logic [127:0] arb_wdata;
  logic         L2_resp;
  logic [127:0] arb_rdata;

  int errors = 0;
  int checks = 0;

  l1_l2_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_resp    (dcache_resp),
    .dcache_rdata   (dcache_rdata),
    .arb_read       (arb_read),
    .arb_write      (arb_write),
    .arb_address    (arb_address),
    .arb_wdata      (arb_wdata),
    .L2_resp        (L2_resp),
    .arb_rdata      (arb_rdata)
  );

  always #5 clk = ~clk;

  // Advance one cycle; the caller then drives inputs for the new cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    icache_read = 1'b0; icache_address = 16'h0;
    dcache_read = 1'b0; dcache_write = 1'b0;
    dcache_address = 16'h0; dcache_wdata = 128'h0;
    L2_resp = 1'b0; arb_rdata = 128'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (arb_read !== 1'b0) begin errors++; $display("FAIL reset_arb_read got=%b exp=0", arb_read); end
    checks++; if (arb_write !== 1'b0) begin errors++; $display("FAIL reset_arb_write got=%b exp=0", arb_write); end
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL reset_icache_resp got=%b exp=0", icache_resp); end
    checks++; if (dcache_resp !== 1'b0) begin errors++; $display("FAIL reset_dcache_resp got=%b exp=0", dcache_resp); end
    checks++; if (arb_address !== 16'h0) begin errors++; $display("FAIL reset_arb_address got=%h exp=0000", arb_address); end
    checks++; if (arb_wdata !== 128'h0) begin errors++; $display("FAIL reset_arb_wdata got=%h exp=0", arb_wdata); end
  endtask

  task automatic test_i_only();
    int hi_cycles;
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    tick();
    icache_read = 1'b1; icache_address = 16'h1230;
    hi_cycles = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (arb_read === 1'b1) hi_cycles++;
      if (c == 1) begin
        checks++; if (arb_address !== 16'h1230) begin errors++; $display("FAIL i_only_addr got=%h exp=1230", arb_address); end
        checks++; if (arb_write !== 1'b0) begin errors++; $display("FAIL i_only_arb_write got=%b exp=0", arb_write); end
      end
      if (c < 5) begin
        checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL i_only_early_resp cycle=%0d got=%b exp=0", c, icache_resp); end
      end
    end
    checks++; if (hi_cycles != 5) begin errors++; $display("FAIL i_only_read_cycles got=%0d exp=5", hi_cycles); end
    L2_resp = 1'b1; arb_rdata = a5;
    #1;
    checks++; if (icache_resp !== 1'b1) begin errors++; $display("FAIL i_only_resp got=%b exp=1", icache_resp); end
    checks++; if (icache_rdata !== a5) begin errors++; $display("FAIL i_only_rdata got=%h exp=%h", icache_rdata, a5); end
    checks++; if (dcache_resp !== 1'b0) begin errors++; $display("FAIL i_only_dresp got=%b exp=0", dcache_resp); end
    icache_read = 1'b0;
    tick();
    L2_resp = 1'b0;
    #1;
    checks++; if (arb_read !== 1'b0) begin errors++; $display("FAIL i_only_read_drop got=%b exp=0", arb_read); end
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL i_only_resp_drop got=%b exp=0", icache_resp); end
  endtask

  task automatic test_d_write();
    logic [127:0] wd;
    wd = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    dcache_write = 1'b1; dcache_address = 16'h4440; dcache_wdata = wd;
    tick();
    checks++; if (arb_write !== 1'b1) begin errors++; $display("FAIL dw_arb_write got=%b exp=1", arb_write); end
    checks++; if (arb_read !== 1'b0) begin errors++; $display("FAIL dw_arb_read got=%b exp=0", arb_read); end
    dcache_address = 16'hFFFF; dcache_wdata = 128'h0;
    tick();
    tick();
    checks++; if (arb_address !== 16'h4440) begin errors++; $display("FAIL dw_addr_hold got=%h exp=4440", arb_address); end
    checks++; if (arb_wdata !== wd) begin errors++; $display("FAIL dw_wdata_hold got=%h exp=%h", arb_wdata, wd); end
    L2_resp = 1'b1;
    #1;
    checks++; if (dcache_resp !== 1'b1) begin errors++; $display("FAIL dw_resp got=%b exp=1", dcache_resp); end
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL dw_iresp got=%b exp=0", icache_resp); end
    dcache_write = 1'b0;
    tick();
    L2_resp = 1'b0;
    #1;
    checks++; if (arb_write !== 1'b0) begin errors++; $display("FAIL dw_write_drop got=%b exp=0", arb_write); end
  endtask

  task automatic test_illegal();
    dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 16'h7770;
    dcache_wdata = 128'h1;
    tick();
    checks++; if (arb_write !== 1'b1) begin errors++; $display("FAIL illegal_write got=%b exp=1", arb_write); end
    checks++; if (arb_read !== 1'b0) begin errors++; $display("FAIL illegal_read got=%b exp=0", arb_read); end
    L2_resp = 1'b1;
    #1;
    checks++; if (dcache_resp !== 1'b1) begin errors++; $display("FAIL illegal_resp got=%b exp=1", dcache_resp); end
    dcache_read = 1'b0; dcache_write = 1'b0;
    tick();
    L2_resp = 1'b0;
  endtask

  task automatic test_contention();
`ifdef ARB_ROUND_ROBIN_EN
    // Both clients request continuously: grants must alternate I, D, I, D
    icache_read = 1'b1; icache_address = 16'h1000;
    dcache_read = 1'b1; dcache_address = 16'h2000;
    for (int r = 0; r < 4; r++) begin
      logic [15:0] exp_addr;
      exp_addr = (r % 2 == 0) ? 16'h1000 : 16'h2000;
      tick();
      checks++; if (arb_address !== exp_addr) begin errors++; $display("FAIL rr_grant round=%0d got=%h exp=%h", r, arb_address, exp_addr); end
      L2_resp = 1'b1;
      #1;
      if (r % 2 == 0) begin
        checks++; if (icache_resp !== 1'b1 || dcache_resp !== 1'b0) begin errors++; $display("FAIL rr_resp round=%0d got i=%b d=%b exp i=1 d=0", r, icache_resp, dcache_resp); end
      end else begin
        checks++; if (icache_resp !== 1'b0 || dcache_resp !== 1'b1) begin errors++; $display("FAIL rr_resp round=%0d got i=%b d=%b exp i=0 d=1", r, icache_resp, dcache_resp); end
      end
      tick();
      L2_resp = 1'b0;
      #1;
      checks++; if (arb_read !== 1'b0) begin errors++; $display("FAIL rr_idle round=%0d got=%b exp=0", r, arb_read); end
    end
    icache_read = 1'b0; dcache_read = 1'b0;
    tick();
`else
    // D wins each contention; I follows after D's resp plus one IDLE cycle
    for (int r = 0; r < 3; r++) begin
      logic [15:0] ia;
      logic [15:0] da;
      ia = 16'h1000 + 16'(r);
      da = 16'h2000 + 16'(r);
      icache_read = 1'b1; icache_address = ia;
      dcache_read = 1'b1; dcache_address = da;
      tick();
      checks++; if (arb_address !== da) begin errors++; $display("FAIL fp_d_first round=%0d got=%h exp=%h", r, arb_address, da); end
      tick();
      L2_resp = 1'b1;
      #1;
      checks++; if (dcache_resp !== 1'b1 || icache_resp !== 1'b0) begin errors++; $display("FAIL fp_d_resp round=%0d got i=%b d=%b exp i=0 d=1", r, icache_resp, dcache_resp); end
      dcache_read = 1'b0;
      tick();
      L2_resp = 1'b0;
      #1;
      checks++; if (arb_read !== 1'b0) begin errors++; $display("FAIL fp_idle round=%0d got=%b exp=0", r, arb_read); end
      tick();
      checks++; if (arb_address !== ia || arb_read !== 1'b1) begin errors++; $display("FAIL fp_i_second round=%0d got addr=%h rd=%b exp addr=%h rd=1", r, arb_address, arb_read, ia); end
      L2_resp = 1'b1;
      #1;
      checks++; if (icache_resp !== 1'b1 || dcache_resp !== 1'b0) begin errors++; $display("FAIL fp_i_resp round=%0d got i=%b d=%b exp i=1 d=0", r, icache_resp, dcache_resp); end
      icache_read = 1'b0;
      tick();
      L2_resp = 1'b0;
    end
`endif
  endtask

  task automatic test_reset_mid();
    dcache_read = 1'b1; dcache_address = 16'h5550;
    tick();
    checks++; if (arb_read !== 1'b1) begin errors++; $display("FAIL rm_granted got=%b exp=1", arb_read); end
    tick();
    tick();
    rst = 1'b1; dcache_read = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (arb_read !== 1'b0 || arb_write !== 1'b0) begin errors++; $display("FAIL rm_strobes got rd=%b wr=%b exp 0 0", arb_read, arb_write); end
    checks++; if (arb_address !== 16'h0) begin errors++; $display("FAIL rm_addr got=%h exp=0000", arb_address); end
    L2_resp = 1'b1;
    #1;
    checks++; if (dcache_resp !== 1'b0 || icache_resp !== 1'b0) begin errors++; $display("FAIL rm_idle_resp got i=%b d=%b exp 0 0", icache_resp, dcache_resp); end
    tick();
    L2_resp = 1'b0;
    #1;
    checks++; if (arb_read !== 1'b0) begin errors++; $display("FAIL rm_no_grant got=%b exp=0", arb_read); end
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_d_write();
    test_illegal();
    test_contention();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
